alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops (logic, add/sub, shifts, SLT) and divide-by-zero finish
// one cycle after accept; MULU (shift-add) and DIVU (restoring) iterate
// BITS cycles in BUSY. Results are held in DONE until out_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   a, b, select          operands and 4-bit opcode (a = shift amount)
//   out_valid / out_ready result handshake (valid only in DONE)
//   c, hi                 primary result; product upper half / remainder
//   zero, cout, ovf, dz   result flags
module alu_seq #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [3:0]      select,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic [BITS-1:0] hi,
  output logic            zero,
  output logic            cout,
  output logic            ovf,
  output logic            dz
);

  localparam int unsigned MSB   = BITS - 1;
  localparam int unsigned CNT_W = $clog2(BITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRA  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  // State and output registers
  logic [1:0]       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [BITS-1:0]  r_c;
  logic [BITS-1:0]  r_hi;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_dz;
  // Iterative datapath: r_wh/r_wl form the running {hi,lo} pair
  logic [BITS-1:0]  r_wh;
  logic [BITS-1:0]  r_wl;
  logic [BITS-1:0]  r_opb;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_state_nxt;
  logic [BITS-1:0]  w_c_nxt;
  logic [BITS-1:0]  w_hi_nxt;
  logic             w_zero_nxt;
  logic             w_cout_nxt;
  logic             w_ovf_nxt;
  logic             w_dz_nxt;
  logic [BITS-1:0]  w_wh_nxt;
  logic [BITS-1:0]  w_wl_nxt;
  logic [BITS-1:0]  w_opb_nxt;
  logic             w_is_div_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [BITS:0]    w_sum;
  logic [BITS:0]    w_diff;
  logic             w_lt;
  logic [BITS-1:0]  w_alu_c;
  logic [BITS-1:0]  w_alu_hi;
  logic             w_alu_cout;
  logic             w_alu_ovf;
  logic             w_alu_dz;

  logic [BITS:0]    w_mul_sum;
  logic [BITS:0]    w_div_rs;
  logic [BITS:0]    w_div_diff;
  logic             w_div_ge;
  logic [BITS-1:0]  w_it_wh;
  logic [BITS-1:0]  w_it_wl;
  logic             w_multi;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

  // Single-cycle result from the live inputs (used only on accept)
  always_comb begin : alu_single
    w_sum      = {1'b0, a} + {1'b0, b};
    w_diff     = {1'b0, a} - {1'b0, b};
    w_lt       = $signed(a) < $signed(b);
    w_alu_c    = '1;
    w_alu_hi   = '0;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    w_alu_dz   = 1'b0;
    case (select)
      OP_AND: w_alu_c = a & b;
      OP_OR:  w_alu_c = a | b;
      OP_XOR: w_alu_c = a ^ b;
      OP_NOR: w_alu_c = ~(a | b);
      OP_ADD: begin
        w_alu_c    = w_sum[MSB:0];
        w_alu_cout = w_sum[BITS];
        w_alu_ovf  = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_c    = w_diff[MSB:0];
        w_alu_cout = w_diff[BITS];
        w_alu_ovf  = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      // Shift amounts >= BITS naturally give zero / sign fill
      OP_SRA:  w_alu_c = $signed(b) >>> a;
      OP_SRL:  w_alu_c = b >> a;
      OP_SLL:  w_alu_c = b << a;
      OP_SLT:  w_alu_c = BITS'(w_lt);
      OP_MULU: w_alu_c = '0;
      // Reached on the single-cycle path only when b == 0
      OP_DIVU: begin
        w_alu_c  = '1;
        w_alu_hi = a;
        w_alu_dz = 1'b1;
      end
      default: w_alu_c = '1;
    endcase
  end

  // One shift-add or restoring-divide step on the working pair
  always_comb begin : iter_step
    w_mul_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : '0);
    w_div_rs   = {r_wh, r_wl[MSB]};
    w_div_diff = w_div_rs - {1'b0, r_opb};
    w_div_ge   = ~w_div_diff[BITS];
    if (r_is_div) begin
      w_it_wh = w_div_ge ? w_div_diff[MSB:0] : w_div_rs[MSB:0];
      w_it_wl = {r_wl[MSB-1:0], w_div_ge};
    end else begin
      w_it_wh = w_mul_sum[BITS:1];
      w_it_wl = {w_mul_sum[0], r_wl[MSB:1]};
    end
  end

  assign w_multi = (select == OP_MULU) || ((select == OP_DIVU) && (b != '0));

  // Next-state and next-output logic
  always_comb begin : fsm_next
    w_state_nxt  = r_state;
    w_c_nxt      = r_c;
    w_hi_nxt     = r_hi;
    w_zero_nxt   = r_zero;
    w_cout_nxt   = r_cout;
    w_ovf_nxt    = r_ovf;
    w_dz_nxt     = r_dz;
    w_wh_nxt     = r_wh;
    w_wl_nxt     = r_wl;
    w_opb_nxt    = r_opb;
    w_is_div_nxt = r_is_div;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_multi) begin
            w_state_nxt  = S_BUSY;
            w_is_div_nxt = (select == OP_DIVU);
            w_wh_nxt     = '0;
            w_wl_nxt     = (select == OP_DIVU) ? a : b;
            w_opb_nxt    = (select == OP_DIVU) ? b : a;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt = S_DONE;
            w_c_nxt     = w_alu_c;
            w_hi_nxt    = w_alu_hi;
            w_zero_nxt  = (w_alu_c == '0);
            w_cout_nxt  = w_alu_cout;
            w_ovf_nxt   = w_alu_ovf;
            w_dz_nxt    = w_alu_dz;
          end
        end
      end
      S_BUSY: begin
        w_wh_nxt  = w_it_wh;
        w_wl_nxt  = w_it_wl;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // Last iteration publishes the result directly
        if (r_cnt == CNT_W'(BITS - 1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_c_nxt     = w_it_wl;
          w_hi_nxt    = w_it_wh;
          w_zero_nxt  = r_is_div ? (w_it_wl == '0) : ({w_it_wh, w_it_wl} == '0);
          w_cout_nxt  = ~r_is_div && (w_it_wh != '0);
          w_ovf_nxt   = 1'b0;
          w_dz_nxt    = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_wh        <= '0;
      r_wl        <= '0;
      r_opb       <= '0;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_c         <= w_c_nxt;
      r_hi        <= w_hi_nxt;
      r_zero      <= w_zero_nxt;
      r_cout      <= w_cout_nxt;
      r_ovf       <= w_ovf_nxt;
      r_dz        <= w_dz_nxt;
      r_wh        <= w_wh_nxt;
      r_wl        <= w_wl_nxt;
      r_opb       <= w_opb_nxt;
      r_is_div    <= w_is_div_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule
